video_crop_core: RTL and testbench
==================================

# video_crop_core

Crop engine placed directly downstream of the AXI-Stream input FIFO. It pops pixels through the FIFO read port and tracks column and row from the start-of-frame and end-of-line markers. Pixels inside a run-time crop window are forwarded on an AXI-Stream master, with TUSER and TLAST regenerated for the cropped frame.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32: pixel word width.
- C_CNT_WIDTH, 12: width of the column/row counters and the crop registers.
- S_AXIS_ACLK  in  1  sole clock, rising edge.
- S_AXIS_ARESETN  in  1  reset; asynchronous, active-low.
- rd_en  out  1  FIFO pop request.
- data_in  in  C_S_AXIS_TDATA_WIDTH  FIFO data; valid the cycle after rd_en.
- empty  in  1  FIFO empty flag (registered; lags the FIFO count by 1 cycle).
- last_in  in  1  end-of-line marker of the popped word.
- user_in  in  1  start-of-frame marker of the popped word.
- crop_x, crop_y  in  C_CNT_WIDTH each  window origin (column, row).
- crop_w, crop_h  in  C_CNT_WIDTH each  window width and height in pixels.
- M_AXIS_TVALID  out  1;  M_AXIS_TREADY  in  1.
- M_AXIS_TDATA  out  C_S_AXIS_TDATA_WIDTH;  M_AXIS_TSTRB  out  C_S_AXIS_TDATA_WIDTH/8, constant all-ones.
- M_AXIS_TUSER  out  1  first pixel of the cropped frame;  M_AXIS_TLAST  out  1  last pixel of a cropped line.
- frame_done  out  1  one-cycle pulse when the last window pixel enters the output buffer.
- err_geom  out  1  sticky flag: line shorter than the window, or start-of-frame arriving mid-frame; cleared only by reset.

## Operation
- FSM states: WAIT_SOF and IN_FRAME.
- WAIT_SOF: popped words with user_in=0 are discarded.
- WAIT_SOF, word with user_in=1:
  - latch crop_x, crop_y, crop_w, crop_h into shadow registers;
  - set x=0, y=0, evaluate the word, go to IN_FRAME.
- IN_FRAME, per popped word:
  - keep the word when x0≤x<x0+w and y0≤y<y0+h;
  - the comparison is done at C_CNT_WIDTH+1 bits, with no wrap.
- Kept-word markers:
  - TUSER=1 iff x==x0 and y==y0;
  - TLAST=1 iff x==x0+w-1, or last_in=1 while inside the window.
  - The second TLAST case also sets err_geom.
- Counter update after each word:
  - last_in=1: x←0, y←y+1;
  - otherwise x←x+1, saturating at all-ones.
- On the kept word with x==x0+w-1 and y==y0+h-1: pulse frame_done and return to WAIT_SOF. The rest of the source frame is discarded.
- user_in=1 in IN_FRAME: set err_geom, restart at x=0, y=0, re-latch the crop registers.
- Degenerate window: crop_w==0 or crop_h==0 emits nothing. The FSM stays in IN_FRAME until the next start-of-frame, with no error.
- Window beyond the frame: only in-frame pixels are emitted. frame_done is not pulsed.
- Crop inputs are sampled only at start-of-frame. Changes mid-frame have no effect.

## Timing
- Pop rule: rd_en=1 only when all of the following hold:
  - empty=0;
  - rd_en was 0 in the previous cycle (this absorbs the one-cycle empty lag);
  - buffer occupancy + in-flight pop < 2.
- Pop rate: at most one pop per two cycles.
- Popped word is evaluated in cycle T+1 (T = rd_en cycle). A kept word is written to the 2-entry output buffer at the T+1 edge. M_AXIS_TVALID rises at T+2 at the earliest.
- Output handshake:
  - transfer when TVALID && TREADY;
  - TDATA, TUSER and TLAST hold stable while TVALID=1 and TREADY=0;
  - TVALID never drops without a transfer.
- Backpressure stops popping within 1 cycle; buffer space covers the in-flight word. No word is lost or duplicated.
- Reset:
  - all outputs 0 (rd_en, M_AXIS_TVALID, TDATA, TUSER, TLAST, frame_done, err_geom), except TSTRB all-ones;
  - FSM=WAIT_SOF, counters 0, buffer empty.
- Reset asserted mid-frame clears everything on assertion. An in-flight FIFO word is ignored.

## Structure
- Package video_crop_pkg holds:
  - state enum {WAIT_SOF, IN_FRAME};
  - C_CNT_WIDTH default;
  - localparam for the buffer depth (2).
- Sub-module axis_out_skid: 2-entry output FIFO with write port, occupancy output, and AXI-Stream master side. The pop-rule occupancy check uses its occupancy output.

## Test plan
- Basic crop: 8×4 frame of pixels 0..31, crop_x=2, crop_y=1, crop_w=3, crop_h=2, TREADY=1.
  - Output 10,11,12,18,19,20.
  - TUSER on 10; TLAST on 12 and 20; frame_done once; err_geom=0.
- Random TREADY (about 30% high) on the basic-crop frame: identical sequence, no loss or duplicate, outputs held stable while stalled.
- Leading words 0xAA,0xBB with user_in=0, then the basic-crop frame: the leading words are dropped; output matches basic crop.
- Window overflow: crop_x=6, crop_w=4 on the 8-wide frame. Each cropped line is 2 pixels with TLAST on the column-7 pixel; err_geom=1; no frame_done.
- Zero width: crop_w=0. No TVALID for the whole frame; err_geom=0.
- Reset mid-frame: assert reset after 3 output transfers. All outputs 0 immediately. A fresh basic-crop frame then produces the full basic-crop result.

Source files
------------

// File: rtl/video_crop_pkg.sv
// Shared types and constants for the video crop engine.
package video_crop_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } crop_state_t;

    localparam int unsigned CNT_WIDTH_DEFAULT = 12;
    localparam int unsigned BUF_DEPTH         = 2;
    localparam int unsigned BUF_CNT_W         = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/video_crop_axis_out_skid.sv
// Two-entry output buffer: write port from the crop logic, AXI-Stream master side.
// The head entry drives the master outputs directly so they hold while stalled.
module axis_out_skid
    import video_crop_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 wr_user,
    input  logic                 wr_last,
    output logic [BUF_CNT_W-1:0] count,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_user,
    output logic                 m_last
);

    localparam logic [BUF_CNT_W-1:0] CNT_ONE  = BUF_CNT_W'(1);
    localparam logic [BUF_CNT_W-1:0] CNT_FULL = BUF_CNT_W'(BUF_DEPTH);

    logic [DATA_W-1:0] tail_data;
    logic              tail_user;
    logic              tail_last;
    logic              pop;

    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            m_data    <= '0;
            m_user    <= 1'b0;
            m_last    <= 1'b0;
            tail_data <= '0;
            tail_user <= 1'b0;
            tail_last <= 1'b0;
        end else if (pop) begin
            if (count == CNT_FULL) begin
                m_data <= tail_data;
                m_user <= tail_user;
                m_last <= tail_last;
                if (wr_en) begin
                    tail_data <= wr_data;
                    tail_user <= wr_user;
                    tail_last <= wr_last;
                end else begin
                    count <= CNT_ONE;
                end
            end else if (wr_en) begin
                m_data <= wr_data;
                m_user <= wr_user;
                m_last <= wr_last;
            end else begin
                count <= '0;
            end
        end else if (wr_en) begin
            // A write while full cannot occur: the pop rule reserves the slot.
            if (count == '0) begin
                m_data <= wr_data;
                m_user <= wr_user;
                m_last <= wr_last;
                count  <= CNT_ONE;
            end else if (count == CNT_ONE) begin
                tail_data <= wr_data;
                tail_user <= wr_user;
                tail_last <= wr_last;
                count     <= CNT_FULL;
            end
        end
    end

endmodule

// File: rtl/video_crop_core.sv
// Crop engine: pops words from the input FIFO, tracks column/row from SOF/EOL
// markers and forwards in-window pixels with regenerated TUSER/TLAST.
module video_crop_core
    import video_crop_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_CNT_WIDTH          = CNT_WIDTH_DEFAULT
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    output logic                              rd_en,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_in,
    input  logic                              empty,
    input  logic                              last_in,
    input  logic                              user_in,
    input  logic [C_CNT_WIDTH-1:0]            crop_x,
    input  logic [C_CNT_WIDTH-1:0]            crop_y,
    input  logic [C_CNT_WIDTH-1:0]            crop_w,
    input  logic [C_CNT_WIDTH-1:0]            crop_h,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TUSER,
    output logic                              M_AXIS_TLAST,
    output logic                              frame_done,
    output logic                              err_geom
);

    localparam int CW = C_CNT_WIDTH;
    typedef logic [CW:0]   wide_t;
    typedef logic [CW-1:0] cnt_t;
    localparam wide_t                WIDE_ONE  = wide_t'(1);
    localparam cnt_t                 CNT_ONE   = cnt_t'(1);
    localparam logic [BUF_CNT_W:0]   BUF_LIMIT = (BUF_CNT_W + 1)'(BUF_DEPTH);

    crop_state_t state, state_next;
    cnt_t x, y, x_next, y_next;
    cnt_t sx, sy, sw, sh, sx_next, sy_next, sw_next, sh_next;
    logic rd_q, run_q, err_q, fd_q;
    logic [BUF_CNT_W-1:0] buf_count;

    logic  sof, in_win, at_xend, at_yend;
    logic  keep, t_user, t_last, err_set, frame_end;
    cnt_t  win_x, win_y, win_w, win_h, cur_x, cur_y;
    wide_t x_w, y_w, x0_w, y0_w, xe_w, ye_w;

    // rd_q marks the cycle in which the popped word is on data_in.
    assign rd_en = run_q && !empty && !rd_q &&
                   (({1'b0, buf_count} + {{BUF_CNT_W{1'b0}}, rd_q}) < BUF_LIMIT);

    assign M_AXIS_TSTRB = '1;
    assign frame_done   = fd_q;
    assign err_geom     = err_q;

    always_comb begin
        sof   = rd_q && user_in;
        win_x = sof ? crop_x : sx;
        win_y = sof ? crop_y : sy;
        win_w = sof ? crop_w : sw;
        win_h = sof ? crop_h : sh;
        cur_x = sof ? '0 : x;
        cur_y = sof ? '0 : y;

        // One extra bit so x0+w never wraps back into range.
        x_w  = {1'b0, cur_x};
        y_w  = {1'b0, cur_y};
        x0_w = {1'b0, win_x};
        y0_w = {1'b0, win_y};
        xe_w = x0_w + {1'b0, win_w};
        ye_w = y0_w + {1'b0, win_h};

        in_win  = (x_w >= x0_w) && (x_w < xe_w) && (y_w >= y0_w) && (y_w < ye_w);
        at_xend = (x_w == xe_w - WIDE_ONE);
        at_yend = (y_w == ye_w - WIDE_ONE);
    end

    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        sx_next    = sx;
        sy_next    = sy;
        sw_next    = sw;
        sh_next    = sh;
        keep       = 1'b0;
        t_user     = 1'b0;
        t_last     = 1'b0;
        err_set    = 1'b0;
        frame_end  = 1'b0;

        if (rd_q) begin
            if (sof) begin
                sx_next = crop_x;
                sy_next = crop_y;
                sw_next = crop_w;
                sh_next = crop_h;
                if (state == IN_FRAME) begin
                    err_set = 1'b1;
                end
            end
            if (state == IN_FRAME || user_in) begin
                state_next = IN_FRAME;
                keep       = in_win;
                t_user     = (cur_x == win_x) && (cur_y == win_y);
                t_last     = at_xend || last_in;
                if (in_win && last_in && !at_xend) begin
                    err_set = 1'b1;
                end
                if (in_win && at_xend && at_yend) begin
                    frame_end  = 1'b1;
                    state_next = WAIT_SOF;
                end
                if (last_in) begin
                    x_next = '0;
                    y_next = cur_y + CNT_ONE;
                end else begin
                    x_next = (&cur_x) ? cur_x : cur_x + CNT_ONE;
                    y_next = cur_y;
                end
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            x     <= '0;
            y     <= '0;
            sx    <= '0;
            sy    <= '0;
            sw    <= '0;
            sh    <= '0;
            rd_q  <= 1'b0;
            run_q <= 1'b0;
            err_q <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            x     <= x_next;
            y     <= y_next;
            sx    <= sx_next;
            sy    <= sy_next;
            sw    <= sw_next;
            sh    <= sh_next;
            rd_q  <= rd_en;
            run_q <= 1'b1;
            err_q <= err_q || err_set;
            fd_q  <= frame_end;
        end
    end

    axis_out_skid #(
        .DATA_W(C_S_AXIS_TDATA_WIDTH)
    ) u_out (
        .clk     (S_AXIS_ACLK),
        .rst_n   (S_AXIS_ARESETN),
        .wr_en   (keep),
        .wr_data (data_in),
        .wr_user (t_user),
        .wr_last (t_last),
        .count   (buf_count),
        .m_valid (M_AXIS_TVALID),
        .m_ready (M_AXIS_TREADY),
        .m_data  (M_AXIS_TDATA),
        .m_user  (M_AXIS_TUSER),
        .m_last  (M_AXIS_TLAST)
    );

endmodule

// File: tb/tb_video_crop_core.sv
// Directed bench for video_crop_core: an 8x4 frame fed through a FIFO model,
// output beats collected by a monitor and compared against a vector table.
module tb_video_crop_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [31:0] data_in;
    logic        empty;
    logic        last_in;
    logic        user_in;
    logic [11:0] crop_x, crop_y, crop_w, crop_h;
    logic        tvalid, tready, tuser, tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        frame_done, err_geom;

    always #5 clk = ~clk;

    video_crop_core #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .C_CNT_WIDTH(12)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .rd_en          (rd_en),
        .data_in        (data_in),
        .empty          (empty),
        .last_in        (last_in),
        .user_in        (user_in),
        .crop_x         (crop_x),
        .crop_y         (crop_y),
        .crop_w         (crop_w),
        .crop_h         (crop_h),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TREADY  (tready),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TSTRB   (tstrb),
        .M_AXIS_TUSER   (tuser),
        .M_AXIS_TLAST   (tlast),
        .frame_done     (frame_done),
        .err_geom       (err_geom)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } word_t;

    typedef struct packed {
        logic [11:0]     cx, cy, cw, ch;
        logic            rnd;
        logic [1:0]      nlead;
        logic [3:0]      n;
        logic [7:0][7:0] px;
        logic [7:0]      usr;
        logic [7:0]      lst;
        logic            err;
        logic [1:0]      fd;
    } vec_t;

    word_t fq[$];
    word_t got[$];
    vec_t  vecs[8];

    int  tests = 0;
    int  fails = 0;
    int  fd_cnt, vcyc, stall_bad;
    bit  rnd_mode = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int cx, input int cy, input int cw, input int ch,
                                input bit rnd, input int nlead, input int n,
                                input logic [63:0] px, input logic [7:0] usr,
                                input logic [7:0] lst, input bit err, input int fd);
        vec_t v;
        v.cx = 12'(cx);  v.cy = 12'(cy);  v.cw = 12'(cw);  v.ch = 12'(ch);
        v.rnd = rnd;     v.nlead = 2'(nlead);  v.n = 4'(n);
        v.px = px;       v.usr = usr;     v.lst = lst;
        v.err = err;     v.fd = 2'(fd);
        return v;
    endfunction

    // FIFO model: data valid the cycle after rd_en, empty lags occupancy by one cycle.
    initial begin
        bit p, e;
        word_t w;
        empty = 1'b1; data_in = '0; last_in = 1'b0; user_in = 1'b0;
        forever begin
            @(negedge clk);
            p = rd_en;
            e = (fq.size() == 0);
            @(posedge clk);
            #1;
            if (p && fq.size() > 0) begin
                w = fq.pop_front();
                data_in = w.d;
                user_in = w.u;
                last_in = w.l;
            end
            empty = e;
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Output monitor: collects transfers, frame_done pulses and stall stability.
    initial begin
        bit ps;
        word_t pw;
        ps = 1'b0;
        pw = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ps && (!tvalid || tdata !== pw.d || tuser !== pw.u || tlast !== pw.l))
                    stall_bad++;
                if (tvalid && tready) got.push_back({tdata, tuser, tlast});
                if (tvalid) vcyc++;
                if (frame_done) fd_cnt++;
                ps = tvalid && !tready;
                pw = {tdata, tuser, tlast};
            end else begin
                ps = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        fq.delete();
        got.delete();
        fd_cnt = 0; vcyc = 0; stall_bad = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input int nlead);
        if (nlead > 0) fq.push_back({32'hAA, 1'b0, 1'b0});
        if (nlead > 1) fq.push_back({32'hBB, 1'b0, 1'b0});
        for (int i = 0; i < 32; i++)
            fq.push_back({32'(i), (i == 0), ((i % 8) == 7)});
    endtask

    task automatic run_case(input int k);
        vec_t v;
        int idle;
        v = vecs[k];
        crop_x = v.cx; crop_y = v.cy; crop_w = v.cw; crop_h = v.ch;
        rnd_mode = v.rnd;
        do_reset();
        push_frame(int'(v.nlead));
        repeat (16) @(posedge clk);
        #1;
        // Window registers are latched at SOF; later changes must be ignored.
        crop_x = 12'd0; crop_y = 12'd0; crop_w = 12'd1; crop_h = 12'd1;
        idle = 0;
        for (int c = 0; c < 3000 && idle < 8; c++) begin
            @(negedge clk);
            if (fq.size() == 0 && !tvalid) idle++;
            else idle = 0;
        end
        chk($sformatf("c%0d_drain", k), 32'(idle >= 8), 32'd1);
        chk($sformatf("c%0d_count", k), 32'(got.size()), 32'(v.n));
        for (int i = 0; i < int'(v.n) && i < got.size(); i++) begin
            chk($sformatf("c%0d_data%0d", k, i), got[i].d, {24'd0, v.px[i]});
            chk($sformatf("c%0d_user%0d", k, i), 32'(got[i].u), 32'(v.usr[i]));
            chk($sformatf("c%0d_last%0d", k, i), 32'(got[i].l), 32'(v.lst[i]));
        end
        chk($sformatf("c%0d_err_geom", k), 32'(err_geom), 32'(v.err));
        chk($sformatf("c%0d_frame_done", k), 32'(fd_cnt), 32'(v.fd));
        chk($sformatf("c%0d_stall_stable", k), 32'(stall_bad), 32'd0);
        if (v.n == 0) chk($sformatf("c%0d_no_valid", k), 32'(vcyc), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"},  32'(rd_en),      32'd0);
        chk({tag, "_tvalid"}, 32'(tvalid),     32'd0);
        chk({tag, "_tdata"},  tdata,           32'd0);
        chk({tag, "_tuser"},  32'(tuser),      32'd0);
        chk({tag, "_tlast"},  32'(tlast),      32'd0);
        chk({tag, "_fdone"},  32'(frame_done), 32'd0);
        chk({tag, "_err"},    32'(err_geom),   32'd0);
        chk({tag, "_tstrb"},  32'(tstrb),      32'hF);
    endtask

    initial begin
        rst_n = 1'b0;
        crop_x = '0; crop_y = '0; crop_w = '0; crop_h = '0;
        fd_cnt = 0; vcyc = 0; stall_bad = 0;
        #22;
        chk_outputs_zero("reset");

        vecs[0] = mk(2, 1, 3, 2, 0, 0, 6, {8'd0, 8'd0, 8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10},
                     8'h01, 8'h24, 0, 1);
        vecs[1] = mk(2, 1, 3, 2, 1, 0, 6, {8'd0, 8'd0, 8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10},
                     8'h01, 8'h24, 0, 1);
        vecs[2] = mk(2, 1, 3, 2, 0, 2, 6, {8'd0, 8'd0, 8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10},
                     8'h01, 8'h24, 0, 1);
        vecs[3] = mk(6, 1, 4, 2, 0, 0, 4, {32'd0, 8'd23, 8'd22, 8'd15, 8'd14},
                     8'h01, 8'h0A, 1, 0);
        vecs[4] = mk(2, 1, 0, 2, 0, 0, 0, 64'd0, 8'h00, 8'h00, 0, 0);
        vecs[5] = mk(5, 3, 3, 1, 0, 0, 3, {40'd0, 8'd31, 8'd30, 8'd29},
                     8'h01, 8'h04, 0, 1);
        vecs[6] = mk(0, 0, 1, 1, 0, 0, 1, 64'd0, 8'h01, 8'h01, 0, 1);
        vecs[7] = mk(2, 1, 3, 0, 0, 0, 0, 64'd0, 8'h00, 8'h00, 0, 0);

        for (int k = 0; k < 8; k++) run_case(k);

        // Reset in the middle of a frame, after three output transfers.
        crop_x = 12'd2; crop_y = 12'd1; crop_w = 12'd3; crop_h = 12'd2;
        rnd_mode = 1'b0;
        do_reset();
        push_frame(0);
        for (int c = 0; c < 2000 && got.size() < 3; c++) @(negedge clk);
        chk("midrst_reach3", 32'(got.size() >= 3), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        fq.delete();
        run_case(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
